// File: rtl/ultimem_mapper_if.sv
// CPU-side bus of the Ultimem mapper: 6502-style phase-2 bus in, memory strobes
// and config read-back out.
interface ultimem_mapper_if #(
  parameter int BANK_WIDTH = 6
);
  logic                   phi2_cpu;
  logic [15:0]            address_cpu;
  logic [7:0]             data_cpu_in;
  logic                   r_w_cpu;
  logic [BANK_WIDTH+12:0] address_mem;
  logic                   _ce_ram;
  logic                   _ce_rom;
  logic                   _we_mem;
  logic                   cfg_rd;
  logic [7:0]             data_cfg_out;

  modport master (
    output phi2_cpu, address_cpu, data_cpu_in, r_w_cpu,
    input  address_mem, _ce_ram, _ce_rom, _we_mem, cfg_rd, data_cfg_out
  );
  modport slave (
    input  phi2_cpu, address_cpu, data_cpu_in, r_w_cpu,
    output address_mem, _ce_ram, _ce_rom, _we_mem, cfg_rd, data_cfg_out
  );
endinterface

// File: rtl/ultimem_mapper.sv
// Banked memory mapper: eight 8 KB CPU blocks remapped to RAM/ROM banks, configured
// through a key-protected 16-byte register window committed on the phi2 falling edge.
module ultimem_mapper #(
  parameter int          BANK_WIDTH = 6,
  parameter logic [15:0] CFG_BASE   = 16'h9FF0
) (
  input logic             clock,
  input logic             _reset,
  ultimem_mapper_if.slave bus
);

  typedef enum logic [1:0] {LOCKED, K1, K2, UNLOCKED} key_t;

  key_t                        key;
  logic [1:0]                  phi_sync;
  logic                        phi_prev;
  logic                        commit;
  logic [15:0]                 lat_addr;
  logic [7:0]                  lat_data;
  logic                        lat_rw;
  logic [7:0][BANK_WIDTH-1:0]  bank;
  logic [7:0]                  ramsel;
  logic [7:0]                  wen;

  logic [2:0] blk;
  logic       mem_sel;
  logic       in_win;
  logic [3:0] off;
  logic       lat_in_win;
  logic [3:0] lat_off;

  // Bus fields are captured while the synchronised phi2 is high, so the commit
  // acts on values that were stable during the whole phase, not on the falling edge.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      phi_sync <= 2'b00;
      phi_prev <= 1'b0;
      lat_addr <= 16'h0000;
      lat_data <= 8'h00;
      lat_rw   <= 1'b1;
    end else begin
      phi_sync <= {phi_sync[0], bus.phi2_cpu};
      phi_prev <= phi_sync[1];
      if (phi_sync[1]) begin
        lat_addr <= bus.address_cpu;
        lat_data <= bus.data_cpu_in;
        lat_rw   <= bus.r_w_cpu;
      end
    end
  end

  assign commit     = phi_prev & ~phi_sync[1];
  assign lat_in_win = (lat_addr[15:4] == CFG_BASE[15:4]);
  assign lat_off    = lat_addr[3:0];

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      key    <= LOCKED;
      ramsel <= 8'b0010_1111;
      wen    <= 8'b0010_1111;
      for (int i = 0; i < 8; i++) bank[i] <= BANK_WIDTH'(i);
    end else if (commit && !lat_rw && lat_in_win) begin
      if (lat_off == 4'd0) begin
        case (key)
          LOCKED:   if (lat_data == 8'h55) key <= K1;
          K1:       key <= (lat_data == 8'hAA) ? K2 : LOCKED;
          K2:       key <= (lat_data == 8'h01) ? UNLOCKED : LOCKED;
          UNLOCKED: if (lat_data == 8'h00) key <= LOCKED;
          default:  key <= LOCKED;
        endcase
      end else if (key == UNLOCKED) begin
        if (lat_off == 4'd2)  wen    <= lat_data;
        if (lat_off == 4'd3)  ramsel <= lat_data;
        if (lat_off[3])       bank[lat_off[2:0]] <= lat_data[BANK_WIDTH-1:0];
      end
    end
  end

  // The upper half of block 4 holds the I/O and config window, never memory.
  assign blk     = bus.address_cpu[15:13];
  assign mem_sel = !(blk == 3'd4 && bus.address_cpu[12]);
  assign in_win  = (bus.address_cpu[15:4] == CFG_BASE[15:4]);
  assign off     = bus.address_cpu[3:0];

  assign bus.address_mem = {bank[blk], bus.address_cpu[12:0]};
  assign bus._ce_ram     = !(bus.phi2_cpu && mem_sel && ramsel[blk]);
  assign bus._ce_rom     = !(bus.phi2_cpu && mem_sel && !ramsel[blk]);
  assign bus._we_mem     = !(bus.phi2_cpu && !bus.r_w_cpu && mem_sel && ramsel[blk] && wen[blk]);
  assign bus.cfg_rd      = bus.phi2_cpu && bus.r_w_cpu && in_win && (off == 4'd0 || key == UNLOCKED);

  always_comb begin
    bus.data_cfg_out = 8'h00;
    if (bus.cfg_rd) begin
      if (off == 4'd0) begin
        case (key)
          LOCKED:   bus.data_cfg_out = 8'h00;
          K1:       bus.data_cfg_out = 8'h01;
          K2:       bus.data_cfg_out = 8'h02;
          default:  bus.data_cfg_out = 8'h80;
        endcase
      end else if (off == 4'd2) bus.data_cfg_out = wen;
      else if (off == 4'd3)     bus.data_cfg_out = ramsel;
      else if (off[3])          bus.data_cfg_out = 8'(bank[off[2:0]]);
      else                      bus.data_cfg_out = 8'hFF;
    end
  end

endmodule

// File: tb/tb_ultimem_mapper.sv
// Directed bench for ultimem_mapper: bus cycles against a behavioural mapper model,
// with a per-cycle compare during phi2 high and hand-computed spot checks.
module tb_ultimem_mapper;
  localparam int          BW = 6;
  localparam logic [15:0] CB = 16'h9FF0;

  logic clock = 1'b0;
  logic _reset = 1'b0;
  always #5 clock = ~clock;

  ultimem_mapper_if #(.BANK_WIDTH(BW)) bus ();
  ultimem_mapper #(.BANK_WIDTH(BW), .CFG_BASE(CB)) dut (.clock(clock), ._reset(_reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // model: state as its read-back code, banks/ramsel/wen as plain integers
  int m_state;
  int m_bank [8];
  int m_ramsel, m_wen;
  int cur_a, cur_d, cur_rw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_ramsel = 'h2F; m_wen = 'h2F;
    for (int i = 0; i < 8; i++) m_bank[i] = i;
  endfunction

  function automatic void model_write(input int a, input int d);
    int o;
    if (a < CB || a >= CB + 16) return;
    o = a - CB;
    if (o == 0) begin
      if (m_state == 0)         m_state = (d == 'h55) ? 1 : 0;
      else if (m_state == 1)    m_state = (d == 'hAA) ? 2 : 0;
      else if (m_state == 2)    m_state = (d == 'h01) ? 'h80 : 0;
      else                      m_state = (d == 0) ? 0 : 'h80;
    end else if (m_state == 'h80) begin
      if (o == 2)      m_wen = d;
      else if (o == 3) m_ramsel = d;
      else if (o >= 8) m_bank[o-8] = d % (1 << BW);
    end
  endfunction

  // Per-cycle compare whenever phi2 is high and the bench is out of reset.
  always @(negedge clock) begin
    if (cmp_en && bus.phi2_cpu === 1'b1) begin
      int a, blk, ram, we, rd, o;
      bit memsel, inwin, e_cfg;
      int e_data;
      a = int'(bus.address_cpu); rd = int'(bus.r_w_cpu);
      blk = a / 8192;
      memsel = !(a >= 'h9000 && a < 'hA000);
      ram = (m_ramsel >> blk) & 1;
      we  = (m_wen >> blk) & 1;
      inwin = (a >= CB && a < CB + 16);
      o = a - CB;
      e_cfg = rd == 1 && inwin && (o == 0 || m_state == 'h80);
      if (!e_cfg)      e_data = 0;
      else if (o == 0) e_data = m_state;
      else if (o == 2) e_data = m_wen;
      else if (o == 3) e_data = m_ramsel;
      else if (o >= 8) e_data = m_bank[o-8];
      else             e_data = 'hFF;
      check("cyc_addr",   32'(bus.address_mem), 32'(m_bank[blk] * 8192 + a % 8192));
      check("cyc_ce_ram", 32'(bus._ce_ram), 32'(!(memsel && ram == 1)));
      check("cyc_ce_rom", 32'(bus._ce_rom), 32'(!(memsel && ram == 0)));
      check("cyc_we",     32'(bus._we_mem), 32'(!(memsel && rd == 0 && ram == 1 && we == 1)));
      check("cyc_cfg_rd", 32'(bus.cfg_rd), 32'(e_cfg));
      check("cyc_data",   32'(bus.data_cfg_out), 32'(e_data));
    end
  end

  task automatic bus_start(input int a, input int d, input int rw);
    cur_a = a; cur_d = d; cur_rw = rw;
    bus.phi2_cpu = 1'b0;
    bus.address_cpu = 16'(a); bus.data_cpu_in = 8'(d); bus.r_w_cpu = rw[0];
    repeat (2) @(posedge clock);
    #1 bus.phi2_cpu = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bus_end();
    bus.phi2_cpu = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    if (cur_rw == 0) model_write(cur_a, cur_d);
  endtask

  task automatic cyc(input int a, input int d, input int rw);
    bus_start(a, d, rw);
    bus_end();
  endtask

  task automatic do_reset();
    cmp_en = 1'b0;
    bus.phi2_cpu = 1'b0;
    _reset = 1'b0;
    repeat (3) @(posedge clock);
    model_reset();
    #1 _reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 cmp_en = 1'b1;
  endtask

  initial begin
    bus.phi2_cpu = 1'b0; bus.address_cpu = 16'h0000; bus.data_cpu_in = 8'h00; bus.r_w_cpu = 1'b1;
    do_reset();

    // idle phase: strobes and read-back quiet
    @(negedge clock);
    check("idle_ce_ram", 32'(bus._ce_ram), 32'd1);
    check("idle_ce_rom", 32'(bus._ce_rom), 32'd1);
    check("idle_cfg_rd", 32'(bus.cfg_rd), 32'd0);

    bus_start('h2000, 0, 1);
    check("rst_addr_2000", 32'(bus.address_mem), 32'h02000);
    check("rst_ce_ram_2000", 32'(bus._ce_ram), 32'd0);
    check("rst_ce_rom_2000", 32'(bus._ce_rom), 32'd1);
    bus_end();
    bus_start('hE000, 0, 1);
    check("rst_ce_rom_E000", 32'(bus._ce_rom), 32'd0);
    check("rst_ce_ram_E000", 32'(bus._ce_ram), 32'd1);
    check("rst_addr_E000", 32'(bus.address_mem), 32'h0E000);
    bus_end();

    // locked: bank write ignored, read not claimed
    cyc('h9FF9, 'h10, 0);
    bus_start('h9FF9, 0, 1);
    check("locked_cfg_rd", 32'(bus.cfg_rd), 32'd0);
    check("locked_data", 32'(bus.data_cfg_out), 32'h00);
    bus_end();

    cyc('h9FF0, 'h55, 0);
    bus_start('h9FF0, 0, 1);
    check("state_k1", 32'(bus.data_cfg_out), 32'h01);
    bus_end();
    bus_start('h9FF0, 'hAA, 0);
    check("win_wr_we", 32'(bus._we_mem), 32'd1);
    check("win_wr_ce", 32'({bus._ce_ram, bus._ce_rom}), 32'b11);
    bus_end();
    cyc('h9FF0, 'h01, 0);
    bus_start('h9FF0, 0, 1);
    check("unlocked_code", 32'(bus.data_cfg_out), 32'h80);
    check("unlocked_cfg_rd", 32'(bus.cfg_rd), 32'd1);
    bus_end();

    bus_start('h9FF9, 0, 1);
    check("bank1_kept", 32'(bus.data_cfg_out), 32'h01);
    bus_end();
    bus_start('h9FFF, 0, 1);
    check("bank7_reset", 32'(bus.data_cfg_out), 32'h07);
    bus_end();
    bus_start('h9FF2, 0, 1);
    check("wen_reset", 32'(bus.data_cfg_out), 32'h2F);
    bus_end();
    bus_start('h9FF1, 0, 1);
    check("unimpl_ff", 32'(bus.data_cfg_out), 32'hFF);
    bus_end();

    cyc('h9FF9, 'h05, 0);
    bus_start('h2345, 0, 1);
    check("remap_2345", 32'(bus.address_mem), 32'h0A345);
    bus_end();
    cyc('h9FFA, 'hFF, 0);
    bus_start('h9FFA, 0, 1);
    check("bank_trunc", 32'(bus.data_cfg_out), 32'h3F);
    bus_end();

    cyc('h9FF2, 'h00, 0);
    bus_start('h0400, 'h12, 0);
    check("wen0_we", 32'(bus._we_mem), 32'd1);
    check("wen0_ce_ram", 32'(bus._ce_ram), 32'd0);
    bus_end();
    cyc('h9FF3, 'hAF, 0);
    cyc('h9FF2, 'h80, 0);
    bus_start('hE000, 'h34, 0);
    check("e000_we", 32'(bus._we_mem), 32'd0);
    check("e000_ce_ram", 32'(bus._ce_ram), 32'd0);
    bus_end();
    bus_start('hC000, 'h34, 0);
    check("rom_no_we", 32'(bus._we_mem), 32'd1);
    check("rom_ce", 32'(bus._ce_rom), 32'd0);
    bus_end();

    cyc('h9FF0, 'h00, 0);
    bus_start('h9FF0, 0, 1);
    check("relocked", 32'(bus.data_cfg_out), 32'h00);
    bus_end();
    cyc('h9FF0, 'h55, 0);
    cyc('h9FF0, 'h77, 0);
    cyc('h9FF0, 'hAA, 0);
    cyc('h9FF0, 'h01, 0);
    bus_start('h9FF0, 0, 1);
    check("bad_key", 32'(bus.data_cfg_out), 32'h00);
    bus_end();

    // reset mid key sequence
    cyc('h9FF0, 'h55, 0);
    cyc('h9FF0, 'hAA, 0);
    do_reset();
    bus_start('h9FF0, 0, 1);
    check("reset_mid_key", 32'(bus.data_cfg_out), 32'h00);
    bus_end();
    bus_start('h9100, 'h99, 0);
    check("io_ce", 32'({bus._ce_ram, bus._ce_rom}), 32'b11);
    check("io_we", 32'(bus._we_mem), 32'd1);
    bus_end();
    bus_start('h8FFF, 0, 1);
    check("blk4_rom", 32'(bus._ce_rom), 32'd0);
    bus_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
